// File: rtl/inject_sched.sv
// inject_sched: per-PE injection controller for a deflection-BFT router port.
// Arbitrates reinjection FIFO against a generator, with rate throttling and run/drain/done.
module inject_sched #(
   parameter int N     = 2,
   parameter int D_W   = 32,
   parameter int A_W   = $clog2(N) + 1,
   parameter int RATE  = 10,
   parameter int LIMIT = 16,
   parameter int WRAP  = 1,
   parameter int QUIET = 4,
   parameter int posx  = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ce,
   input  logic               start,
   input  logic               gen_v,
   input  logic [A_W-2:0]     gen_addr,
   input  logic [D_W-1:0]     gen_d,
   output logic               gen_rdy,
   input  logic [A_W+D_W+1:0] o,
   input  logic               slot_free,
   output logic [A_W+D_W+1:0] i,
   output logic [15:0]        sent_cnt,
   output logic [15:0]        rx_cnt,
   output logic               drop,
   output logic               done
);

   localparam int E_W = A_W + D_W;
   localparam int pos_unused = posx;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t         state;
   logic [E_W-1:0] fifo [2];
   logic [1:0]     cnt;
   logic [6:0]     win;
   logic [7:0]     credit;
   logic [15:0]    quiet;

   logic o_v, o_defl, defl_in, full, fifo_empty;
   logic credit_ok, below_limit, active;
   logic reinj, new_acc, charged, push, idle;

   assign o_v        = o[E_W+1];
   assign o_defl     = o[E_W];
   assign defl_in    = o_v & o_defl;
   assign full       = (cnt == 2'd2);
   assign fifo_empty = (cnt == 2'd0);

   assign credit_ok   = (RATE >= 100) || ({24'd0, credit} < 32'(RATE));
   assign below_limit = {16'd0, sent_cnt} < 32'(LIMIT);
   assign active      = slot_free & ((state == S_RUN) | (state == S_DRAIN));

   assign gen_rdy = ce & slot_free & (state == S_RUN) & fifo_empty
                  & credit_ok & below_limit;

   // Deflected traffic always wins the slot; gen_rdy already excludes a non-empty FIFO.
   assign reinj   = active & ~fifo_empty & ((WRAP == 0) || credit_ok);
   assign new_acc = gen_v & gen_rdy & ~reinj;
   assign charged = new_acc | (reinj & (WRAP != 0));
   assign push    = defl_in & (~full | reinj);
   assign idle    = fifo_empty & ~o_v & ~i[E_W+1];

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         i        <= '0;
         sent_cnt <= '0;
         rx_cnt   <= '0;
         drop     <= 1'b0;
         done     <= 1'b0;
         fifo[0]  <= '0;
         fifo[1]  <= '0;
         cnt      <= '0;
         win      <= '0;
         credit   <= '0;
         quiet    <= '0;
         state    <= S_IDLE;
      end else if (!ce) begin
         i <= '0;
      end else begin
         if (reinj)
            i <= {2'b10, fifo[0]};
         else if (new_acc)
            i <= {2'b10, 1'b0, gen_addr, gen_d};
         else
            i <= '0;

         case ({push, reinj})
            2'b01: begin
               fifo[0] <= fifo[1];
               cnt     <= cnt - 2'd1;
            end
            2'b10: begin
               fifo[cnt[0]] <= o[E_W-1:0];
               cnt          <= cnt + 2'd1;
            end
            2'b11: begin
               if (cnt == 2'd1) begin
                  fifo[0] <= o[E_W-1:0];
               end else begin
                  fifo[0] <= fifo[1];
                  fifo[1] <= o[E_W-1:0];
               end
            end
            default: ;
         endcase

         drop <= defl_in & full & ~reinj;

         if (o_v & ~o_defl)
            rx_cnt <= sat_inc(rx_cnt);
         if (new_acc)
            sent_cnt <= sat_inc(sent_cnt);

         if (win == 7'd99) begin
            win    <= '0;
            credit <= '0;
         end else begin
            win <= win + 7'd1;
            if (charged)
               credit <= credit + 8'd1;
         end

         unique case (state)
            S_IDLE: ;
            S_RUN: begin
               if (!below_limit)
                  state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (idle) begin
                  quiet <= quiet + 16'd1;
                  if (32'(quiet) + 32'd1 >= 32'(QUIET)) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end
               end else begin
                  quiet <= '0;
               end
            end
            S_DONE: begin
               if (defl_in) begin
                  state <= S_DRAIN;
                  done  <= 1'b0;
                  quiet <= '0;
               end
            end
         endcase

         if (start) begin
            sent_cnt <= '0;
            rx_cnt   <= '0;
            credit   <= '0;
            win      <= '0;
            quiet    <= '0;
            done     <= 1'b0;
            state    <= S_RUN;
         end
      end
   end

endmodule

// File: doc/inject_sched.md
Name: inject_sched

Overview:
- Per-PE injection controller between a client traffic source and its deflection-BFT router port.
- Arbitrates one router injection slot between two requesters:
  - packets deflected back to the PE, held in a 2-entry reinjection FIFO;
  - new packets from a valid/ready generator.
- Applies percent-rate throttling and a packet LIMIT.
- Sequences run/drain/done and raises done once the PE is quiet.

Parameters:
- N, 2, total number of clients
- D_W, 32, data width
- A_W, $clog2(N)+1, address width
- RATE, 10, permitted injections per 100-cycle window (0..100)
- LIMIT, 16, new packets injected per run
- WRAP, 1, 1 = reinjections consume rate credit; 0 = reinjection unthrottled
- QUIET, 4, consecutive idle ce-cycles required in DRAIN before DONE
- posx, 0, this PE's position

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- ce  in  1  clock enable; all state holds when 0
- start  in  1  one-cycle pulse: clear counters, begin run
- gen_v  in  1  new packet valid
- gen_addr  in  A_W-1  new packet destination
- gen_d  in  D_W  new packet data
- gen_rdy  out  1  new packet accepted this cycle when gen_v=1
- o  in  A_W+D_W+2  router-to-client message {v, defl, addr[A_W], data}
- slot_free  in  1  router injection slot free this cycle
- i  out  A_W+D_W+2  client-to-router message, registered
- sent_cnt  out  16  new packets injected this run
- rx_cnt  out  16  delivered packets received this run
- drop  out  1  one-cycle pulse: deflected packet lost because FIFO full
- done  out  1  run complete

Behaviour:
- Reset (rst=0, async):
  - i=0, sent_cnt=0, rx_cnt=0, drop=0, done=0.
  - FIFO empty, window counter=0, credit=0, quiet=0.
  - State=IDLE.
- Ungated cycle: every rule below applies only on posedge with ce=1. With ce=0, i<=0 and nothing else changes.
- Receive path, from o:
  - v=1, defl=0: rx_cnt++.
  - v=1, defl=1: push into FIFO.
  - v=1, defl=1 with FIFO full and no pop this cycle: packet discarded, drop=1 next cycle.
  - Push and pop in the same cycle with FIFO full: legal, no drop.
  - A pushed entry is not eligible for pop until the following cycle.
- Rate window:
  - win counts 0..99 and wraps to 0.
  - On wrap, credit<=0; otherwise credit increments per charged injection.
  - credit_ok = (credit < RATE). RATE=0 blocks all charged injections; RATE>=100 never blocks.
- Arbitration: applies only when state is RUN or DRAIN and slot_free=1.
  - Priority 1: reinjection. FIFO non-empty and (WRAP==0 or credit_ok) → pop the head; i <= {1, 0, head.addr, head.data}. The defl bit is cleared. Charged only if WRAP=1.
  - Priority 2: new packet. Allowed only when no reinjection is selected this cycle; handshake rule below.
- gen_rdy / new-packet handshake:
  - gen_rdy = ce & slot_free & (state==RUN) & fifo_empty & credit_ok & (sent_cnt<LIMIT).
  - gen_rdy must not depend on gen_v.
  - On gen_v & gen_rdy: i <= {1, 0, {1'b0, gen_addr}, gen_d}; sent_cnt++; charged.
  - No selection in a cycle → i<=0.
- Latency: accepted request at cycle t appears on i at t+1.
- FSM:
  - IDLE: no injection, FIFO still captures. start → RUN.
  - RUN: sent_cnt==LIMIT → DRAIN. With LIMIT=0, go to DRAIN on the first cycle.
  - DRAIN: reinjection only. quiet++ when FIFO empty & o.v=0 & i.v=0, else quiet<=0. quiet==QUIET → DONE.
  - DONE: done=1. o.v=1 & defl=1 → DRAIN with done<=0. start → RUN.
- start semantics (any state):
  - Clears sent_cnt, rx_cnt, credit, win, quiet; goes to RUN.
  - FIFO contents are kept.
  - start has priority over all other transitions.
- Counters: saturate at 16'hFFFF.
- Reset asserted mid-run: everything returns to reset values immediately; any packet in flight on i is dropped.

Test Plan:
- Unthrottled run:
  - Setup: RATE=100, LIMIT=4, gen_v=1, slot_free=1, start at t0.
  - Response: i.v=1 on t2..t5 with gen data; sent_cnt=4; gen_rdy=0 from t5.
  - Completion: o idle → done=1 at t5+QUIET+1.
- Rate throttle:
  - Setup: RATE=10, LIMIT=16, continuous gen_v.
  - Response: exactly 10 injections in cycles 0..99 of each window, none in the rest; sent_cnt=16 after the second window.
- Reinjection priority:
  - Stimulus: o={1,1,addr=1,data=7} while gen_v=1.
  - Response: next-but-one cycle i={1,0,1,7}; gen_rdy=0 during that cycle; new packet follows one cycle later.
- FIFO overflow:
  - Stimulus: slot_free=0, three consecutive deflected arrivals.
  - Response: first two stored; drop=1 one cycle after the third.
  - Then slot_free=1: the two stored packets are reinjected in order.
- Backpressure and ce:
  - Stimulus: slot_free=0 or ce=0 for 5 cycles mid-run.
  - Response: i=0, gen_rdy=0; counters and win frozen under ce=0.
- Reset mid-run:
  - Stimulus: rst=0 asynchronously at sent_cnt=3.
  - Response: i=0 and all counters 0 before the next edge; state IDLE, no injection until start.
